pipe_hazard_ctrl: RTL

//  Central stall/flush/exception sequencer for the 5-stage pipeline. Drives the enable, flush and

---
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/exception sequencer for the 5-stage pipeline: Tuse/Tnew and MDU hazards plus exception entry.
// Optional HAZARD_STAT_EN adds a saturating stall-cycle counter on o_stall_cnt.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [4:0] i_d_rs,
  input  logic [4:0] i_d_rt,
  input  logic [1:0] i_d_tuse_rs,
  input  logic [1:0] i_d_tuse_rt,
  input  logic       i_d_md,
  input  logic [4:0] i_e_a3,
  input  logic [1:0] i_e_tnew,
  input  logic [4:0] i_m_a3,
  input  logic [1:0] i_m_tnew,
  input  logic [1:0] i_e_md_op,
  input  logic       i_exc_req,
  output logic       o_pc_en,
  output logic       o_fd_en,
  output logic       o_de_flush,
  output logic       o_req,
  output logic       o_md_start,
  output logic       o_md_busy
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0] o_stall_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, ENTER = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] busy_q, busy_d;

  logic haz_e_rs, haz_e_rt, haz_m_rs, haz_m_rt;
  logic data_stall, md_stall, raw_stall, stall;
  logic e_md_valid, is_idle;

  // Register 0 is hardwired, so a match on it is never a real dependency.
  assign haz_e_rs = (i_d_rs != 5'd0) && (i_d_rs == i_e_a3) && (i_d_tuse_rs < i_e_tnew);
  assign haz_e_rt = (i_d_rt != 5'd0) && (i_d_rt == i_e_a3) && (i_d_tuse_rt < i_e_tnew);
  assign haz_m_rs = (i_d_rs != 5'd0) && (i_d_rs == i_m_a3) && (i_d_tuse_rs < i_m_tnew);
  assign haz_m_rt = (i_d_rt != 5'd0) && (i_d_rt == i_m_a3) && (i_d_tuse_rt < i_m_tnew);

  assign e_md_valid = (i_e_md_op == 2'd1) || (i_e_md_op == 2'd2);
  assign is_idle    = (state_q == IDLE);

  assign data_stall = haz_e_rs | haz_e_rt | haz_m_rs | haz_m_rt;
  assign md_stall   = i_d_md & (o_md_busy | e_md_valid);
  assign raw_stall  = data_stall | md_stall;

  // Exception request wins over stalls; the handler-fetch cycle never stalls.
  always_comb begin
    state_d    = state_q;
    o_req      = 1'b0;
    o_md_start = 1'b0;
    stall      = 1'b0;
    if (i_reset_n) begin
      o_req      = i_exc_req & is_idle;
      o_md_start = e_md_valid & ~i_exc_req & is_idle;
      stall      = raw_stall & is_idle & ~o_req;
    end
    case (state_q)
      IDLE:    if (i_exc_req) state_d = ENTER;
      ENTER:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_pc_en    = ~stall;
  assign o_fd_en    = ~stall;
  assign o_de_flush = stall;
  assign o_md_busy  = (busy_q != '0);

  always_comb begin
    busy_d = busy_q;
    if (o_md_start) begin
      busy_d = (i_e_md_op == 2'd1) ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
    end else if (busy_q != '0) begin
      busy_d = busy_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) stall_cnt_q <= '0;
    else            stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
